// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// oversampling constants and the baud divider helper.
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit check).
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  // Tick index of the start-bit midpoint, counted from the falling edge
  localparam int MID_START  = 7;
  // Tick index of the midpoint of each following bit, counted from the previous sample
  localparam int MID_BIT    = 15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_WAITHI = 3'd5
  } rx_state_t;

  // Clock cycles per oversample tick, integer-truncated
  function automatic int uart_div(input int clk_hz, input int baud);
    return clk_hz / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// Small synchronous FIFO with first-word fall-through read data.
// Push/pop contract: pop_i is honoured only when not empty; push_i is
// honoured when not full, or when full and a pop is honoured in the same
// cycle (the pop frees the slot). accept_o reports whether the push landed.
module rx_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             accept_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok, push_ok;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == CW'(DEPTH));
  assign pop_ok   = pop_i && !empty_o;
  assign push_ok  = push_i && (!full_o || pop_ok);
  assign accept_o = push_ok;
  assign count_o  = count_q;
  // Head entry shown directly; forced to zero while nothing is stored
  assign rdata_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Occupancy next-state: a simultaneous push and pop leaves it unchanged
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: synchronises uart_in, oversamples 16x per bit, assembles
// 8N1 frames LSB first and buffers accepted bytes in rx_sync_fifo.
// irq pulses for one cycle per byte that actually lands in the FIFO.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit between data and stop).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          uart_in,
  input  logic          rd,
  input  logic          clr_err,
  output logic [7:0]    q,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          irq,
  output logic          ferr,
  output logic          overrun,
  output logic          perr,
  output rx_state_t     state_dbg
);

  localparam int DIV = uart_div(CLK_HZ, BAUD);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  // Synchroniser and edge history; idle line is high
  logic meta_q, rxs_q, rxs_prev_q;
  logic [DW-1:0] div_q;
  logic tick, start_fall;

  rx_state_t state_q;
  logic [3:0] sc_q;
  logic [2:0] bit_idx_q;
  logic [7:0] shift_q;
  logic       push_q;
  logic       drop_q;
  logic       ferr_q, perr_q, overrun_q, irq_q;

  logic stop_sample, ferr_set, perr_set, overrun_set;
  logic accept;

  assign tick       = (div_q == DW'(DIV - 1));
  assign start_fall = (state_q == ST_IDLE) && rxs_prev_q && !rxs_q;

  // Two-flop synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q     <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      meta_q     <= uart_in;
      rxs_q      <= meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // Oversample divider, realigned to the start-bit falling edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (start_fall || tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  // Frame FSM: samples start, data, optional parity and stop at mid-bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sc_q      <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      push_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      push_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_fall) begin
            state_q <= ST_START;
            sc_q    <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (sc_q == 4'(MID_START)) begin
              if (rxs_q) begin
                state_q <= ST_IDLE;
              end else begin
                state_q   <= ST_DATA;
                sc_q      <= '0;
                bit_idx_q <= '0;
                drop_q    <= 1'b0;
              end
            end else begin
              sc_q <= sc_q + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (sc_q == 4'(MID_BIT)) begin
              shift_q <= {rxs_q, shift_q[7:1]};
              sc_q    <= '0;
              if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state_q <= ST_PARITY;
`else
                state_q <= ST_STOP;
`endif
              end else begin
                bit_idx_q <= bit_idx_q + 3'd1;
              end
            end else begin
              sc_q <= sc_q + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            if (sc_q == 4'(MID_BIT)) begin
              drop_q  <= (rxs_q != ^shift_q);
              sc_q    <= '0;
              state_q <= ST_STOP;
            end else begin
              sc_q <= sc_q + 4'd1;
            end
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            if (sc_q == 4'(MID_BIT)) begin
              sc_q <= '0;
              if (rxs_q) begin
                push_q  <= !drop_q;
                state_q <= ST_IDLE;
              end else begin
                state_q <= ST_WAITHI;
              end
            end else begin
              sc_q <= sc_q + 4'd1;
            end
          end
        end
        ST_WAITHI: begin
          if (rxs_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stop_sample = (state_q == ST_STOP) && tick && (sc_q == 4'(MID_BIT));
  assign ferr_set    = stop_sample && !rxs_q;
`ifdef UART_RX_PARITY_EN
  assign perr_set    = (state_q == ST_PARITY) && tick && (sc_q == 4'(MID_BIT)) &&
                       (rxs_q != ^shift_q);
`else
  assign perr_set    = 1'b0;
`endif
  assign overrun_set = push_q && !accept;

  // Sticky error flags and the receive interrupt; a new error beats clr_err
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      irq_q <= accept;
      if (ferr_set)         ferr_q <= 1'b1;
      else if (clr_err)     ferr_q <= 1'b0;
      if (perr_set)         perr_q <= 1'b1;
      else if (clr_err)     perr_q <= 1'b0;
      if (overrun_set)      overrun_q <= 1'b1;
      else if (clr_err)     overrun_q <= 1'b0;
    end
  end

  rx_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_i   (push_q),
    .wdata_i  (shift_q),
    .pop_i    (rd),
    .accept_o (accept),
    .rdata_o  (q),
    .count_o  (count),
    .empty_o  (empty),
    .full_o   (full)
  );

  assign irq       = irq_q;
  assign ferr      = ferr_q;
  assign perr      = perr_q;
  assign overrun   = overrun_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: 32 clk per bit (DIV=2).
// Optional feature macro: UART_RX_PARITY_EN (frames then carry a parity bit).
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int CLK_HZ  = 3200000;
  localparam int BAUD    = 100000;
  localparam int DEPTH   = 16;
  localparam int CW      = 5;
  localparam int BIT_CLK = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          uart_in = 1'b1;
  logic          rd = 1'b0;
  logic          clr_err = 1'b0;
  logic [7:0]    q;
  logic [CW-1:0] count;
  logic          empty, full, irq, ferr, overrun, perr;
  rx_state_t     state_dbg;

  int tests = 0;
  int fails = 0;
  int irq_cnt = 0;
  int irq_wide = 0;
  int i0;
  bit irq_prev = 1'b0;
  bit found;

  uart_rx_fifo #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .uart_in   (uart_in),
    .rd        (rd),
    .clr_err   (clr_err),
    .q         (q),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .irq       (irq),
    .ferr      (ferr),
    .overrun   (overrun),
    .perr      (perr),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // irq pulse counter, sampled away from the active edge
  always @(negedge clk) begin
    if (irq === 1'b1) begin
      irq_cnt++;
      if (irq_prev) irq_wide++;
    end
    irq_prev = (irq === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: one bit time, starting and ending on a falling clock edge
  task automatic send_bit(input logic b);
    uart_in = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_val, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^data) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    send_bit(stop_val);
  endtask

  // Returns at the first falling edge where the FSM has left STOP
  task automatic wait_stop_done(output bit ok);
    bit seen;
    int n;
    ok = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!ok && n < 1000) begin
      @(negedge clk);
      n++;
      if (state_dbg == ST_STOP) seen = 1'b1;
      else if (seen) ok = 1'b1;
    end
  endtask

  task automatic pop_one();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_q", q, 8'h00);
    check("rst_count", count, 5'd0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_ferr", ferr, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_perr", perr, 1'b0);
    check("rst_state", state_dbg, ST_IDLE);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 1: single frame 0x55, irq one clk after the stop sample
    i0 = irq_cnt;
    fork
      send_frame(8'h55, 1'b1, 1'b0);
      begin
        wait_stop_done(found);
        check("t1_stop_seen", found, 1'b1);
        check("t1_irq_at_sample", irq, 1'b0);
        @(negedge clk);
        check("t1_irq_after", irq, 1'b1);
      end
    join
    check("t1_irq_count", irq_cnt - i0, 1);
    check("t1_q", q, 8'h55);
    check("t1_count", count, 5'd1);
    check("t1_empty", empty, 1'b0);
    pop_one();
    check("t1_empty_after_rd", empty, 1'b1);
    check("t1_count_after_rd", count, 5'd0);
    pop_one();
    check("t1_rd_when_empty", count, 5'd0);

    // 2: short low glitch is rejected at the start-bit midpoint
    i0 = irq_cnt;
    uart_in = 1'b0;
    repeat (8) @(negedge clk);
    check("t2_in_start", state_dbg, ST_START);
    uart_in = 1'b1;
    repeat (40) @(negedge clk);
    check("t2_idle", state_dbg, ST_IDLE);
    check("t2_count", count, 5'd0);
    check("t2_no_irq", irq_cnt - i0, 0);

    // 3: framing error, line held low, then recovery
    i0 = irq_cnt;
    send_frame(8'hA3, 1'b0, 1'b0);
    repeat (64) @(negedge clk);
    check("t3_ferr", ferr, 1'b1);
    check("t3_count", count, 5'd0);
    check("t3_no_irq", irq_cnt - i0, 0);
    check("t3_waithi", state_dbg, ST_WAITHI);
    uart_in = 1'b1;
    repeat (8) @(negedge clk);
    check("t3_idle", state_dbg, ST_IDLE);
    send_frame(8'h3C, 1'b1, 1'b0);
    check("t3_next_count", count, 5'd1);
    check("t3_next_q", q, 8'h3C);
    check("t3_ferr_still", ferr, 1'b1);
    pulse_clr();
    check("t3_ferr_clr", ferr, 1'b0);
    pop_one();

    // 4: fill beyond depth, then push with simultaneous pop while full
    i0 = irq_cnt;
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, 1'b0);
    check("t4_full", full, 1'b1);
    check("t4_count", count, 5'd16);
    check("t4_overrun", overrun, 1'b1);
    check("t4_irqs", irq_cnt - i0, 16);
    check("t4_head", q, 8'h00);
    pulse_clr();
    check("t4_overrun_clr", overrun, 1'b0);
    i0 = irq_cnt;
    fork
      send_frame(8'h77, 1'b1, 1'b0);
      begin
        wait_stop_done(found);
        check("t4_stop_seen", found, 1'b1);
        pop_one();
      end
    join
    check("t4_pp_count", count, 5'd16);
    check("t4_pp_overrun", overrun, 1'b0);
    check("t4_pp_irq", irq_cnt - i0, 1);
    for (int i = 1; i <= 16; i++) begin
      check("t4_order", q, (i == 16) ? 8'h77 : 8'(i));
      pop_one();
    end
    check("t4_drained", empty, 1'b1);

    // 5: push and pop in the same cycle at count 3
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0);
    check("t5_count3", count, 5'd3);
    i0 = irq_cnt;
    fork
      send_frame(8'h44, 1'b1, 1'b0);
      begin
        wait_stop_done(found);
        check("t5_stop_seen", found, 1'b1);
        pop_one();
      end
    join
    check("t5_count_same", count, 5'd3);
    check("t5_irq", irq_cnt - i0, 1);
    check("t5_head", q, 8'h22);
    pop_one();
    check("t5_next", q, 8'h33);

    // 6: reset during data bit 4, then a clean frame
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    uart_in = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_in_data", state_dbg, ST_DATA);
    reset = 1'b1;
    @(negedge clk);
    check("t6_q", q, 8'h00);
    check("t6_count", count, 5'd0);
    check("t6_empty", empty, 1'b1);
    check("t6_full", full, 1'b0);
    check("t6_irq", irq, 1'b0);
    check("t6_ferr", ferr, 1'b0);
    check("t6_overrun", overrun, 1'b0);
    check("t6_perr", perr, 1'b0);
    check("t6_state", state_dbg, ST_IDLE);
    uart_in = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("t6_no_partial", count, 5'd0);
    i0 = irq_cnt;
    send_frame(8'hC7, 1'b1, 1'b0);
    check("t6_c7_q", q, 8'hC7);
    check("t6_c7_count", count, 5'd1);
    check("t6_c7_irq", irq_cnt - i0, 1);

`ifdef UART_RX_PARITY_EN
    // Parity mismatch: byte dropped, perr set
    i0 = irq_cnt;
    send_frame(8'h01, 1'b1, 1'b1);
    check("par_perr", perr, 1'b1);
    check("par_count", count, 5'd1);
    check("par_no_irq", irq_cnt - i0, 0);
    check("par_ferr", ferr, 1'b0);
    pulse_clr();
    check("par_clr", perr, 1'b0);
`else
    check("perr_tied", perr, 1'b0);
`endif

    check("irq_width", irq_wide, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
